// File: rtl/multimem_dbuf.sv
// Framebuffer memory: byte-granular write port, registered wide read port
// (all lanes, all bytes of one pixel), optional front/back double buffering
// with frame-synchronised swap, back-buffer clear sweep and write bypass.
//
// Clear FSM states
//   state    | meaning
//   ST_IDLE  | no sweep; writes accepted, swaps allowed
//   ST_SWEEP | writing CLEAR_VALUE to pixel cnt of the back buffer; wr_ready=0
//   ST_DONE  | one-cycle clear_done pulse; writes accepted again
module multimem_dbuf #(
    parameter int         BYTES_PER_PIXEL = 3,
    parameter int         LANES           = 2,
    parameter int         DEPTH           = 2048,
    parameter int         NUM_BUFFERS     = 2,
    parameter int         BYPASS          = 1,
    parameter logic [7:0] CLEAR_VALUE     = 8'h00,
    localparam int        LW = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int        PW = $clog2(DEPTH),
    localparam int        BW = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1,
    localparam int        RW = LANES * BYTES_PER_PIXEL * 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    output logic          wr_ready,
    input  logic [LW-1:0] wr_lane,
    input  logic [PW-1:0] wr_pixel,
    input  logic [BW-1:0] wr_byte,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [PW-1:0] rd_pixel,
    output logic [RW-1:0] rd_data,
    input  logic          rd_frame_end,
    input  logic          swap_req,
    output logic          swap_ack,
    output logic          front_sel,
    input  logic          clear_req,
    output logic          clear_done
);

    localparam int NSLOT = NUM_BUFFERS * LANES * BYTES_PER_PIXEL;
    localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} clr_state_t;

    clr_state_t    state;
    logic [PW-1:0] cnt;
    logic          pending;
    logic          wbuf;
    logic          rbuf;
    logic          clr_wr;
    logic          wr_acc;
    logic          swap_now;
    logic [RW-1:0] rd_next;

    // One byte-wide array per (buffer, lane, byte) slot, so every slot has a
    // single read port and at most one write per cycle.
    logic [7:0] mem [0:NSLOT-1][0:DEPTH-1];

    function automatic logic [SW-1:0] slot(input logic bsel, input int lane, input int bidx);
        return SW'((int'(bsel) * LANES + lane) * BYTES_PER_PIXEL + bidx);
    endfunction

    // Single-buffer builds keep everything in buffer 0.
    assign rbuf = (NUM_BUFFERS == 2) ? front_sel  : 1'b0;
    assign wbuf = (NUM_BUFFERS == 2) ? ~front_sel : 1'b0;

    assign clr_wr   = (state == ST_SWEEP);
    assign wr_acc   = wr_en && wr_ready
                      && (int'(wr_lane) < LANES)
                      && (int'(wr_byte) < BYTES_PER_PIXEL);
    assign swap_now = (pending || swap_req) && rd_frame_end && (state == ST_IDLE);

    // RAM write: clear sweep owns the port while wr_ready is low.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            for (int l = 0; l < LANES; l++) begin
                for (int b = 0; b < BYTES_PER_PIXEL; b++) begin
                    mem[slot(wbuf, l, b)][cnt] <= CLEAR_VALUE;
                end
            end
        end else if (wr_acc) begin
            mem[slot(wbuf, int'(wr_lane), int'(wr_byte))][wr_pixel] <= wr_data;
        end
    end

    // Next read word: stored bytes, optionally overridden by a same-cycle write.
    always_comb begin
        rd_next = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int b = 0; b < BYTES_PER_PIXEL; b++) begin
                rd_next[(l*BYTES_PER_PIXEL+b)*8 +: 8] = mem[slot(rbuf, l, b)][rd_pixel];
                if ((BYPASS != 0) && (wbuf == rbuf)) begin
                    if (clr_wr && (cnt == rd_pixel)) begin
                        rd_next[(l*BYTES_PER_PIXEL+b)*8 +: 8] = CLEAR_VALUE;
                    end else if (wr_acc && (wr_pixel == rd_pixel)
                                 && (int'(wr_lane) == l) && (int'(wr_byte) == b)) begin
                        rd_next[(l*BYTES_PER_PIXEL+b)*8 +: 8] = wr_data;
                    end
                end
            end
        end
    end

    // Registered read port; rd_en=0 holds the last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_next;
        end
    end

    // Clear sweep FSM with registered wr_ready / clear_done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            wr_ready   <= 1'b1;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state    <= ST_SWEEP;
                        cnt      <= '0;
                        wr_ready <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (cnt == PW'(DEPTH - 1)) begin
                        state      <= ST_DONE;
                        wr_ready   <= 1'b1;
                        clear_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

    // Swap request latch; the exchange waits for a frame end with no sweep active.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= 1'b0;
            front_sel <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            swap_ack <= swap_now;
            if (swap_now) begin
                pending <= 1'b0;
                if (NUM_BUFFERS == 2) begin
                    front_sel <= ~front_sel;
                end
            end else if (swap_req) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multimem_dbuf.sv
// Bench for multimem_dbuf: four instances (default double buffer, 16-deep
// double buffer, 16-deep single buffer with and without bypass) share one
// stimulus stream; read results go through an expectation queue.
module tb_multimem_dbuf;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_lane = 1'b0;
    logic [10:0] wr_pixel = '0;
    logic [1:0]  wr_byte = '0;
    logic [7:0]  wr_data = '0;
    logic        rd_en = 1'b0;
    logic [10:0] rd_pixel = '0;
    logic        rd_frame_end = 1'b0;
    logic        swap_req = 1'b0;
    logic        clear_req = 1'b0;

    logic [47:0] rdd   [4];
    logic        wrdy  [4];
    logic        ack   [4];
    logic        fsel  [4];
    logic        cdone [4];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          batch;
        int          inst;
        int          lo;
        int          w;
        logic [63:0] exp;
        string       tag;
    } sb_t;

    sb_t sbq[$];
    int  rd_issued = 0;
    int  rd_done   = 0;

    always #5 clk = ~clk;

    multimem_dbuf u_big (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ready(wrdy[0]), .wr_lane(wr_lane),
        .wr_pixel(wr_pixel), .wr_byte(wr_byte), .wr_data(wr_data), .rd_en(rd_en),
        .rd_pixel(rd_pixel), .rd_data(rdd[0]), .rd_frame_end(rd_frame_end),
        .swap_req(swap_req), .swap_ack(ack[0]), .front_sel(fsel[0]),
        .clear_req(clear_req), .clear_done(cdone[0])
    );

    multimem_dbuf #(.DEPTH(16)) u_small (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ready(wrdy[1]), .wr_lane(wr_lane),
        .wr_pixel(wr_pixel[3:0]), .wr_byte(wr_byte), .wr_data(wr_data), .rd_en(rd_en),
        .rd_pixel(rd_pixel[3:0]), .rd_data(rdd[1]), .rd_frame_end(rd_frame_end),
        .swap_req(swap_req), .swap_ack(ack[1]), .front_sel(fsel[1]),
        .clear_req(clear_req), .clear_done(cdone[1])
    );

    multimem_dbuf #(.DEPTH(16), .NUM_BUFFERS(1), .BYPASS(1)) u_byp1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ready(wrdy[2]), .wr_lane(wr_lane),
        .wr_pixel(wr_pixel[3:0]), .wr_byte(wr_byte), .wr_data(wr_data), .rd_en(rd_en),
        .rd_pixel(rd_pixel[3:0]), .rd_data(rdd[2]), .rd_frame_end(rd_frame_end),
        .swap_req(swap_req), .swap_ack(ack[2]), .front_sel(fsel[2]),
        .clear_req(clear_req), .clear_done(cdone[2])
    );

    multimem_dbuf #(.DEPTH(16), .NUM_BUFFERS(1), .BYPASS(0)) u_byp0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ready(wrdy[3]), .wr_lane(wr_lane),
        .wr_pixel(wr_pixel[3:0]), .wr_byte(wr_byte), .wr_data(wr_data), .rd_en(rd_en),
        .rd_pixel(rd_pixel[3:0]), .rd_data(rdd[3]), .rd_frame_end(rd_frame_end),
        .swap_req(swap_req), .swap_ack(ack[3]), .front_sel(fsel[3]),
        .clear_req(clear_req), .clear_done(cdone[3])
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void expect_rd(input int inst, input int lo, input int w,
                                      input logic [63:0] exp, input string tag);
        sb_t e;
        e.batch = rd_issued;
        e.inst  = inst;
        e.lo    = lo;
        e.w     = w;
        e.exp   = exp;
        e.tag   = tag;
        sbq.push_back(e);
    endfunction

    task automatic pop_check();
        sb_t         e;
        logic [63:0] mask;
        logic [63:0] got;
        while (sbq.size() > 0 && sbq[0].batch < rd_done) begin
            e    = sbq.pop_front();
            mask = (64'd1 << e.w) - 64'd1;
            got  = (64'(rdd[e.inst]) >> e.lo) & mask;
            check_val(e.tag, got, e.exp);
        end
    endtask

    always @(posedge clk) if (rd_en) rd_done <= rd_done + 1;
    always @(negedge clk) pop_check();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int lane, input int px, input int b, input logic [7:0] d);
        wr_en    = 1'b1;
        wr_lane  = lane[0];
        wr_pixel = px[10:0];
        wr_byte  = b[1:0];
        wr_data  = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input int px);
        rd_en    = 1'b1;
        rd_pixel = px[10:0];
        tick();
        rd_en = 1'b0;
        rd_issued++;
    endtask

    task automatic swap_now();
        swap_req     = 1'b1;
        rd_frame_end = 1'b1;
        tick();
        swap_req     = 1'b0;
        rd_frame_end = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        int acks;
        int acks_b;
        int ack_cyc;
        int low;
        int dones;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rd_data", 64'(rdd[0]), 64'h0);
        check_val("rst_front_sel", 64'(fsel[0]), 64'h0);
        check_val("rst_swap_ack", 64'(ack[0]), 64'h0);
        check_val("rst_clear_done", 64'(cdone[1]), 64'h0);
        check_val("rst_wr_ready", 64'(wrdy[1]), 64'h1);
        reset = 1'b1;
        tick();

        // back-buffer writes then frame-end swap
        wr(1, 2047, 0, 8'h41);
        wr(1, 2046, 0, 8'h42);
        swap_now();
        check_val("t1_swap_ack", 64'(ack[0]), 64'h1);
        check_val("t1_front_sel", 64'(fsel[0]), 64'h1);
        tick();
        check_val("t1_swap_ack_drop", 64'(ack[0]), 64'h0);
        expect_rd(0, 24, 8, 64'h41, "t1_big_px2047");
        expect_rd(1, 24, 8, 64'h41, "t1_small_px15");
        expect_rd(2, 24, 8, 64'h41, "t1_byp1_px15");
        rd(2047);
        expect_rd(0, 24, 8, 64'h42, "t1_big_px2046");
        rd(2046);

        // bypass vs read-first on the single-buffer instances
        wr(0, 5, 2, 8'h11);
        wr(0, 5, 0, 8'h22);
        wr(1, 5, 0, 8'h33);
        wr(0, 5, 3, 8'h99);
        wr_en = 1'b1; wr_lane = 1'b0; wr_pixel = 11'd5; wr_byte = 2'd2; wr_data = 8'h45;
        expect_rd(2, 16, 8, 64'h45, "t2_bypass_new");
        expect_rd(3, 16, 8, 64'h11, "t2_readfirst_old");
        expect_rd(2, 0, 8, 64'h22, "t2_bypass_other_byte");
        expect_rd(2, 24, 8, 64'h33, "t2_bad_byte_dropped");
        rd(5);
        wr_en = 1'b0;
        expect_rd(3, 16, 8, 64'h45, "t2_read_after_write");
        rd(5);

        // swap timing: requests at 10 and 15, frame end at 40
        acks = 0; acks_b = 0; ack_cyc = -1;
        for (int c = 0; c <= 45; c++) begin
            if (ack[0]) begin acks++; ack_cyc = c; end
            if (ack[2]) acks_b++;
            if (c == 40) check_val("t3_front_hold", 64'(fsel[0]), 64'h1);
            swap_req     = (c == 10 || c == 15);
            rd_frame_end = (c == 40);
            tick();
        end
        swap_req = 1'b0; rd_frame_end = 1'b0;
        check_val("t3_ack_count", 64'(acks), 64'd1);
        check_val("t3_ack_cycle", 64'(ack_cyc), 64'd41);
        check_val("t3_front_toggled", 64'(fsel[0]), 64'h0);
        check_val("t3_nb1_ack_count", 64'(acks_b), 64'd1);
        check_val("t3_nb1_front_held", 64'(fsel[2]), 64'h0);

        // clear sweep on the 16-deep double buffer
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        low = 0; dones = 0;
        for (int c = 1; c <= 30; c++) begin
            if (!wrdy[1]) low++;
            if (cdone[1]) dones++;
            wr_lane = 1'b0; wr_pixel = 11'd3; wr_byte = 2'd1; wr_data = 8'h77;
            wr_en = (c == 8);
            tick();
        end
        wr_en = 1'b0;
        check_val("t4_ready_low_cycles", 64'(low), 64'd16);
        check_val("t4_done_pulses", 64'(dones), 64'd1);
        swap_now();
        for (int p = 0; p < 16; p++) begin
            expect_rd(1, 0, 48, 64'h0, $sformatf("t4_clr_px%0d", p));
            if (p == 5) expect_rd(2, 0, 48, 64'h0, "t4_nb1_clr_px5");
            rd(p);
        end

        // swap requested during a sweep waits for the next frame end after it
        acks = 0; ack_cyc = -1;
        for (int c = 0; c <= 35; c++) begin
            if (ack[1]) begin acks++; ack_cyc = c; end
            if (c == 25) check_val("t5_front_hold", 64'(fsel[1]), 64'h1);
            clear_req    = (c == 0);
            swap_req     = (c == 3);
            rd_frame_end = (c == 3 || c == 25);
            tick();
        end
        clear_req = 1'b0; swap_req = 1'b0; rd_frame_end = 1'b0;
        check_val("t5_ack_count", 64'(acks), 64'd1);
        check_val("t5_ack_cycle", 64'(ack_cyc), 64'd26);
        check_val("t5_front_toggled", 64'(fsel[1]), 64'h0);

        // reset mid-sweep at cnt=7
        swap_now();
        wr(0, 0, 0, 8'h5a);
        wr(0, 10, 0, 8'h5a);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (7) tick();
        check_val("t6_ready_low_mid", 64'(wrdy[1]), 64'h0);
        reset = 1'b0;
        #1;
        check_val("t6_rst_ready", 64'(wrdy[1]), 64'h1);
        check_val("t6_rst_front", 64'(fsel[1]), 64'h0);
        check_val("t6_rst_done", 64'(cdone[1]), 64'h0);
        tick();
        reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (cdone[1]) dones++;
            tick();
        end
        check_val("t6_no_done", 64'(dones), 64'd0);
        expect_rd(1, 0, 8, 64'h00, "t6_px0_cleared");
        rd(0);
        expect_rd(1, 0, 8, 64'h5a, "t6_px10_kept");
        rd(10);

        // a new sweep starts again at pixel 0
        wr(0, 0, 0, 8'h5a);
        wr(0, 10, 0, 8'h5a);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        swap_now();
        check_val("t6_front_after_swap", 64'(fsel[1]), 64'h1);
        expect_rd(1, 0, 8, 64'h00, "t6_restart_px0");
        rd(0);
        expect_rd(1, 0, 8, 64'h5a, "t6_restart_px10_kept");
        rd(10);

        repeat (3) tick();
        check_val("sb_empty", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multimem_dbuf.md
Name: multimem_dbuf

Overview:
- Parametrised successor to the byte-write / wide-read framebuffer memory.
- Single clock domain. Byte-granular write port fed by the UART/command path; registered wide read port (all lanes, all bytes of one pixel) feeding the row scanner.
- Adds optional double buffering with frame-synchronised swap, a hardware back-buffer clear sweep, and read-during-write bypass.

Parameters:
- BYTES_PER_PIXEL, 3, bytes per pixel (RGB888 = 3).
- LANES, 2, rows driven in parallel (PIXEL_HEIGHT / PIXEL_HALFHEIGHT).
- DEPTH, 2048, pixels per lane per buffer.
- NUM_BUFFERS, 2, 1 = single buffer, 2 = front/back double buffer.
- BYPASS, 1, 1 = same-cycle write to the displayed pixel is forwarded to rd_data.
- CLEAR_VALUE, 8'h00, byte value written by the clear sweep.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  byte write strobe; accepted only when wr_ready=1.
- wr_ready  out  1  0 while a clear sweep is running.
- wr_lane  in  max(1,clog2(LANES))  target lane.
- wr_pixel  in  clog2(DEPTH)  target pixel index.
- wr_byte  in  max(1,clog2(BYTES_PER_PIXEL))  byte within pixel.
- wr_data  in  8  byte value.
- rd_en  in  1  read clock enable.
- rd_pixel  in  clog2(DEPTH)  pixel index to read.
- rd_data  out  LANES*BYTES_PER_PIXEL*8  byte (l,b) at bits [(l*BYTES_PER_PIXEL+b)*8 +: 8].
- rd_frame_end  in  1  scanner frame-boundary pulse.
- swap_req  in  1  request front/back exchange (pulse).
- swap_ack  out  1  1-cycle pulse when the swap executes.
- front_sel  out  1  index of the displayed buffer.
- clear_req  in  1  start back-buffer clear (pulse).
- clear_done  out  1  1-cycle pulse after the last clear write.

Behaviour:
- Reset values (async assert, sync-safe deassert): rd_data=0, front_sel=0, swap_ack=0, clear_done=0, wr_ready=1, swap pending=0, clear FSM=IDLE. RAM contents are not reset.
- Buffers:
  - NUM_BUFFERS=2: writes and clears target buffer !front_sel; reads target front_sel.
  - NUM_BUFFERS=1: all traffic targets buffer 0; front_sel is held at 0.
- Write: when wr_en && wr_ready, byte (wr_lane, wr_pixel, wr_byte) is written at the clk edge. A write with wr_byte >= BYTES_PER_PIXEL or wr_lane >= LANES is silently dropped. A write with wr_en=1 and wr_ready=0 is dropped; the source must hold it until wr_ready=1.
- Read:
  - rd_data updates on the clk edge where rd_en=1, showing the contents of rd_pixel. Latency is 1 cycle.
  - rd_en=0 holds rd_data.
  - A read issued one cycle after a write to the same location returns the new data.
- Bypass (BYPASS=1): if in the same cycle rd_en=1, an accepted write (or clear write) targets the read buffer, and its pixel equals rd_pixel, the written byte(s) replace the old value in the registered rd_data (write-first). Other bytes return the stored data. BYPASS=0 returns old data (read-first).
- Swap:
  - swap_req sets pending. A second swap_req while pending has no further effect.
  - The swap executes on the first edge where pending=1, rd_frame_end=1 and the clear FSM is IDLE. At that edge front_sel toggles, pending clears, and swap_ack=1 for 1 cycle.
  - swap_req and rd_frame_end in the same cycle swap on that edge.
  - NUM_BUFFERS=1: swap_ack still pulses at the frame end; front_sel does not change.
- Clear FSM:
  - IDLE --clear_req--> SWEEP (cnt=0, wr_ready=0).
  - SWEEP writes CLEAR_VALUE to every byte of every lane at pixel cnt of the back buffer each cycle, incrementing cnt.
  - On cnt=DEPTH-1: write, then go to DONE.
  - DONE: clear_done=1 for 1 cycle, wr_ready=1, then IDLE.
  - A sweep takes DEPTH cycles plus 1 for DONE.
  - clear_req during SWEEP or DONE is ignored. With NUM_BUFFERS=1 the sweep clears the displayed buffer.
- Reset asserted mid-sweep or mid-pending aborts the operation; RAM is left partially cleared.

Test Plan:
- Write 'A' to (lane1, pixel 2047, byte0) and 'B' to (lane1, pixel 2046, byte0), swap at frame end, then read pixel 2047 -> rd_data[31:24]=8'h41 one cycle after rd_en; swap_ack pulses once; front_sel=1.
- BYPASS=1, NUM_BUFFERS=1: in the same cycle write 'E' to (lane0, pixel 5, byte2) and read pixel 5 -> rd_data[23:16]=8'h45 on the next edge. BYPASS=0 returns the previous byte.
- swap_req at cycle 10, rd_frame_end at cycle 40 -> front_sel toggles at the cycle-40 edge and swap_ack is high only in cycle 41. Two swap_req pulses before the frame end -> a single toggle.
- DEPTH=16: clear_req -> wr_ready=0 for 16 cycles and clear_done pulses once. A write attempted during the sweep is dropped. After swap, every pixel reads all CLEAR_VALUE.
- swap_req and rd_frame_end arrive during a clear -> the swap is deferred until the clear completes and the next rd_frame_end, then executes.
- Assert reset mid-sweep at cnt=7 -> wr_ready=1, front_sel=0, no clear_done; a new clear_req restarts from pixel 0.
